// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: operation
// encodings, FSM states, the default operand width and an op decoder.
// Optional feature macro used by the unit: MULTDIV_DIVZERO_EXC_EN.
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } op_ctrl_t;

  // Split an opcode into its two orthogonal properties.
  function automatic op_ctrl_t decode_op(input op_e op);
    op_ctrl_t c;
    case (op)
      OP_MULT:  c = '{is_div: 1'b0, is_signed: 1'b1};
      OP_MULTU: c = '{is_div: 1'b0, is_signed: 1'b0};
      OP_DIV:   c = '{is_div: 1'b1, is_signed: 1'b1};
      OP_DIVU:  c = '{is_div: 1'b1, is_signed: 1'b0};
      default:  c = '{is_div: 1'b0, is_signed: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control unit (master) and the
// multiply/divide unit (slave). div_zero exists only when
// MULTDIV_DIVZERO_EXC_EN is defined.
interface mult_div_unit_if #(
  parameter int WIDTH = mult_div_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULTDIV_DIVZERO_EXC_EN
  logic             div_zero;
`endif

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
`ifdef MULTDIV_DIVZERO_EXC_EN
    , input div_zero
`endif
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
`ifdef MULTDIV_DIVZERO_EXC_EN
    , output div_zero
`endif
  );

endinterface

// File: rtl/mult_div_sign_fix.sv
// Sign correction for the unsigned core: turns the raw product, or the raw
// quotient/remainder pair, into the final hi/lo values.
module mult_div_sign_fix
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               is_div,
  input  logic               neg_res,  // product / quotient must be negated
  input  logic               neg_rem,  // remainder must be negated
  input  logic [2*WIDTH-1:0] raw,      // {remainder, quotient} or product
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_neg;
  logic [WIDTH-1:0]   rem_neg;

  assign prod_neg = -raw;
  assign quo_neg  = -raw[WIDTH-1:0];
  assign rem_neg  = -raw[2*WIDTH-1:WIDTH];

  // Select the corrected halves for the operation class.
  always_comb begin
    // NOTE: both outputs are assigned on every path, so no latch is inferred.
    if (is_div) begin
      lo = neg_res ? quo_neg : raw[WIDTH-1:0];
      hi = neg_rem ? rem_neg : raw[2*WIDTH-1:WIDTH];
    end else begin
      {hi, lo} = neg_res ? prod_neg : raw;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle on operand
// magnitudes, followed by a sign-fix cycle. Define MULTDIV_DIVZERO_EXC_EN
// to short-circuit divide by zero and raise div_zero instead.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Architectural and iteration state.
  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc;      // partial remainder/product : quotient/multiplier
  logic [WIDTH-1:0]   opnd;     // divisor or multiplicand magnitude
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
`ifdef MULTDIV_DIVZERO_EXC_EN
  logic               div_zero_q;
`endif

  // Acceptance-side decode.
  op_ctrl_t           ctrl;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH:0]   acc_init;
  logic [WIDTH-1:0]   opnd_init;

  // Iteration step.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH:0]   acc_next;

  // Sign-fixed results, written in FIX.
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Decode the request and form operand magnitudes for acceptance.
  always_comb begin
    ctrl  = decode_op(op_e'(bus.op));
    a_neg = ctrl.is_signed & bus.a[WIDTH-1];
    b_neg = ctrl.is_signed & bus.b[WIDTH-1];
    mag_a = a_neg ? -bus.a : bus.a;
    mag_b = b_neg ? -bus.b : bus.b;
    if (ctrl.is_div) begin
      acc_init  = {{(WIDTH+1){1'b0}}, mag_a};
      opnd_init = mag_b;
    end else begin
      acc_init  = {{(WIDTH+1){1'b0}}, mag_b};
      opnd_init = mag_a;
    end
  end

  // One unsigned iteration: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum  = acc[2*WIDTH:WIDTH] + {1'b0, opnd & {WIDTH{acc[0]}}};
    div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd};
    if (is_div) begin
      if (div_diff[WIDTH+1]) begin
        acc_next = {acc[2*WIDTH-1:0], 1'b0};
      end else begin
        acc_next = {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
    end
  end

  mult_div_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .is_div  (is_div),
    .neg_res (neg_res),
    .neg_rem (neg_rem),
    .raw     (acc[2*WIDTH-1:0]),
    .hi      (fix_hi),
    .lo      (fix_lo)
  );

  // Control FSM and iteration datapath; every output is registered here.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      is_div     <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
`ifdef MULTDIV_DIVZERO_EXC_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
`ifdef MULTDIV_DIVZERO_EXC_EN
      div_zero_q <= 1'b0;
`endif
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            is_div  <= ctrl.is_div;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            acc     <= acc_init;
            opnd    <= opnd_init;
            cnt     <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            state   <= RUN;
`ifdef MULTDIV_DIVZERO_EXC_EN
            // Divide by zero bypasses the datapath and leaves hi/lo alone.
            if (ctrl.is_div && (bus.b == '0)) begin
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
              state      <= DONE;
            end
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
`ifdef MULTDIV_DIVZERO_EXC_EN
  assign bus.div_zero = div_zero_q;
`endif

endmodule
